// File: rtl/sync_mod_counter_pkg.sv
// Shared types and helpers for the modulo-N counter.
// Direction encoding, parameter legality and constant helpers.
package sync_mod_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(n)) r = r + 1;
    end
    return r;
  endfunction

  function automatic int max_val(input int m);
    return m - 1;
  endfunction

  function automatic bit legal(input int w, input int m);
    return (w >= 1) && (w <= 30) && (m >= 2)
        && (clog2(m) <= w);
  endfunction

endpackage

// File: rtl/sync_mod_prescaler.sv
// Clock-enable divider: one step pulse every PRESCALE enabled cycles.
// clr restarts the division phase.
module sync_mod_prescaler
  import sync_mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  if (PRESCALE < 1) begin : g_bad
    $error("PRESCALE must be >= 1");
  end

  if (PRESCALE == 1) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, clr};
    assign step = en;
  end else begin : g_div
    localparam int PW = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST =
      PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    // phase counter, advances only while enabled
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        pre <= '0;
      end else if (en) begin
        if (pre == LAST) pre <= '0;
        else pre <= pre + 1'b1;
      end
    end

    assign step = en && (pre == LAST);
  end

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous modulo-N up/down counter with load, clear and prescaler.
// Optional Gray output: define SYNC_MOD_COUNTER_GRAY_EN.
module sync_mod_counter
  import sync_mod_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
`ifdef SYNC_MOD_COUNTER_GRAY_EN
  output logic [WIDTH-1:0] q_gray,
`endif
  output logic             load_err
);

  if (!legal(WIDTH, MODULUS)) begin : g_bad
    $error("illegal WIDTH/MODULUS");
  end

  localparam logic [WIDTH-1:0] MAXV =
    WIDTH'(max_val(MODULUS));
  localparam logic [WIDTH:0] MODV =
    (WIDTH+1)'(MODULUS);

  logic             step;
  logic [WIDTH-1:0] nq;
  logic             nwrap;
  logic             nerr;

  sync_mod_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr | load),
    .step(step)
  );

  // next count: clr > load > step > hold
  always_comb begin
    nq    = q;
    nwrap = 1'b0;
    nerr  = 1'b0;
    if (clr) begin
      nq = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MODV) begin
        nq = load_val;
      end else begin
        nq   = MAXV;
        nerr = 1'b1;
      end
    end else if (step) begin
      if (dir_t'(up_dn) == DIR_UP) begin
        if (q == MAXV) begin
          nq    = '0;
          nwrap = 1'b1;
        end else begin
          nq = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          nq    = MAXV;
          nwrap = 1'b1;
        end else begin
          nq = q - 1'b1;
        end
      end
    end
  end

  // count, pulse and optional Gray registers
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
`ifdef SYNC_MOD_COUNTER_GRAY_EN
      q_gray   <= '0;
`endif
    end else begin
      q        <= nq;
      wrap     <= nwrap;
      load_err <= nerr;
`ifdef SYNC_MOD_COUNTER_GRAY_EN
      q_gray   <= nq ^ (nq >> 1);
`endif
    end
  end

  assign tc = (dir_t'(up_dn) == DIR_UP)
            ? (q == MAXV) : (q == '0);

endmodule

// File: tb/tb_sync_mod_counter.sv
// Directed bench for sync_mod_counter (MODULUS=10, PRESCALE 1 and 3).
// Expected results are queued at drive time and popped after the edge.
module tb_sync_mod_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up_dn, clr, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap, load_err;
`ifdef SYNC_MOD_COUNTER_GRAY_EN
  logic [3:0] q_gray;
  logic [3:0] q_gray2;
`endif

  logic       rst2, en2;
  logic       up2  = 1'b1;
  logic       clr2 = 1'b0;
  logic       ld2  = 1'b0;
  logic [3:0] lv2  = 4'd0;
  logic [3:0] q2;
  logic       tc2, wrap2, err2;

  sync_mod_counter #(
    .WIDTH(4), .MODULUS(10), .PRESCALE(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .clr(clr), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap),
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    .q_gray(q_gray),
`endif
    .load_err(load_err)
  );

  sync_mod_counter #(
    .WIDTH(4), .MODULUS(10), .PRESCALE(3)
  ) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .up_dn(up2),
    .clr(clr2), .load(ld2), .load_val(lv2),
    .q(q2), .tc(tc2), .wrap(wrap2),
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    .q_gray(q_gray2),
`endif
    .load_err(err2)
  );

  typedef struct packed {
    logic [3:0] q;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];
  int checks = 0;
  int errors = 0;
  int mpre   = 0;
  int mq2    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, expv);
    end
  endtask

  task automatic drive(input logic r, e, u, c, l,
                       input logic [3:0] lv,
                       input logic [3:0] eq,
                       input logic ew, ee);
    exp_t x;
    rst = r; en = e; up_dn = u;
    clr = c; load = l; load_val = lv;
    sb.push_back('{q: eq, wrap: ew, err: ee});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("q", 32'(q), 32'(x.q));
    chk("wrap", 32'(wrap), 32'(x.wrap));
    chk("load_err", 32'(load_err), 32'(x.err));
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    chk("q_gray", 32'(q_gray),
        32'(x.q ^ (x.q >> 1)));
`endif
  endtask

  task automatic tick2(input logic e);
    exp_t x;
    logic w;
    en2 = e;
    w = 1'b0;
    if (e) begin
      if (mpre == 2) begin
        mpre = 0;
        if (mq2 == 9) begin
          mq2 = 0;
          w = 1'b1;
        end else begin
          mq2 = mq2 + 1;
        end
      end else begin
        mpre = mpre + 1;
      end
    end
    sb2.push_back('{q: 4'(mq2), wrap: w, err: 1'b0});
    @(posedge clk);
    #1;
    x = sb2.pop_front();
    chk("pre_q", 32'(q2), 32'(x.q));
    chk("pre_wrap", 32'(wrap2), 32'(x.wrap));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst2 = 1'b1; en2 = 1'b0;
    // reset with en high
    drive(1, 1, 1, 0, 0, 4'd0, 4'd0, 0, 0);
    drive(1, 1, 1, 0, 0, 4'd0, 4'd0, 0, 0);
    chk("tc_reset", 32'(tc), 32'd0);

    // count up through the wrap
    for (int i = 1; i <= 12; i++) begin
      drive(0, 1, 1, 0, 0, 4'd0, 4'(i % 10),
            (i % 10) == 0, 0);
      chk("tc_up", 32'(tc), 32'((i % 10) == 9));
    end

    // clear, then count down through the wrap
    drive(0, 1, 1, 1, 0, 4'd0, 4'd0, 0, 0);
    up_dn = 1'b0;
    #1;
    chk("tc_dn0", 32'(tc), 32'd1);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd9, 1, 0);
    chk("tc_dn9", 32'(tc), 32'd0);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd8, 0, 0);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd7, 0, 0);

    // loads: saturate, boundaries, load beats step
    drive(0, 0, 0, 0, 1, 4'd12, 4'd9, 0, 1);
    drive(0, 0, 0, 0, 0, 4'd0, 4'd9, 0, 0);
    drive(0, 0, 0, 0, 1, 4'd10, 4'd9, 0, 1);
    drive(0, 0, 0, 0, 1, 4'd9, 4'd9, 0, 0);
    drive(0, 1, 0, 0, 1, 4'd5, 4'd5, 0, 0);
    drive(0, 0, 1, 0, 0, 4'd0, 4'd5, 0, 0);
    drive(0, 1, 1, 0, 0, 4'd0, 4'd6, 0, 0);
    drive(0, 1, 1, 0, 0, 4'd0, 4'd7, 0, 0);

    // reset beats clr and an out-of-range load
    drive(1, 1, 1, 1, 1, 4'd12, 4'd0, 0, 0);
    drive(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0);
    // clr beats load
    drive(0, 1, 1, 1, 1, 4'd12, 4'd0, 0, 0);

    // prescaled instance
    rst2 = 1'b0;
    for (int i = 0; i < 9; i++) tick2(1'b1);
    chk("pre_q_after9", 32'(q2), 32'd3);
    tick2(1'b1);
    tick2(1'b0);
    tick2(1'b0);
    tick2(1'b1);
    tick2(1'b1);
    for (int i = 0; i < 20; i++) tick2(1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
